dram_stream_checker: RTL

- Traffic-pattern source and read-back checker sitting directly on the DRAMCON user data path.
- Drives D_DIN, advancing on each D_W; compares every D_DOUT beat qualified by D_DOUTEN against the regenerated pattern.
- Replaces ad-hoc counter/compare logic in test tops and reports error count, first failing beat index and completion.
- Request sequencing (D_REQ/D_INITADR/D_ELEM) stays in the top-level test state machine.

---
 rtl/dram_stream_checker_pkg.sv | 19 +
 rtl/dram_stream_checker_pattern_gen.sv | 58 +++++
 rtl/dram_stream_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dram_stream_checker_pkg.sv
// rtl/dram_stream_checker_pkg.sv - shared constants, state type and LFSR step for the DRAM stream checker
package dram_stream_checker_pkg;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [31:0] LANE_SALT = 32'h01010101;
    localparam logic        MODE_INC  = 1'b0;
    localparam logic        MODE_LFSR = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Galois form: shift right, fold the polynomial back in when a 1 falls out
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/dram_stream_checker_pattern_gen.sv
// rtl/dram_stream_checker_pattern_gen.sv - stream_pattern_gen: registered word/beat pattern source
module stream_pattern_gen
    import dram_stream_checker_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_mode,
    input  logic [31:0]           i_seed,
    input  logic                  i_adv,
    output logic [LANES*32-1:0]   o_beat
);

    logic                 r_mode;
    logic [31:0]          r_word;
    logic [LANES*32-1:0]  r_beat;
    logic [31:0]          w_load_word;
    logic [31:0]          w_next_word;
    logic [31:0]          w_word_d;
    logic [LANES*32-1:0]  w_beat_d;

    function automatic logic [LANES*32-1:0] make_beat(input logic [31:0] w);
        logic [31:0] salt;
        salt = '0;
        for (int j = 0; j < LANES; j++) begin
            make_beat[j*32 +: 32] = w ^ salt;
            salt = salt + LANE_SALT;
        end
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed starts at 1
    always_comb begin
        w_load_word = ((i_mode == MODE_LFSR) && (i_seed == 32'd0)) ? 32'd1 : i_seed;
        w_next_word = (r_mode == MODE_INC) ? (r_word + 32'd1) : lfsr_step(r_word);
        w_word_d    = i_load ? w_load_word : w_next_word;
        w_beat_d    = make_beat(w_word_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode <= MODE_INC;
            r_word <= '0;
            r_beat <= '0;
        end else if (i_load) begin
            r_mode <= i_mode;
            r_word <= w_word_d;
            r_beat <= w_beat_d;
        end else if (i_adv) begin
            r_word <= w_word_d;
            r_beat <= w_beat_d;
        end
    end

    assign o_beat = r_beat;

endmodule

// File: rtl/dram_stream_checker.sv
// rtl/dram_stream_checker.sv - DRAM user-path write pattern source and read-back checker
module dram_stream_checker
    import dram_stream_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CMP_PIPE   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_mode,
    input  logic [31:0]            i_seed,
    input  logic [31:0]            i_expect_n,
    input  logic                   i_d_w,
    output logic [DATA_WIDTH-1:0]  o_d_din,
    input  logic                   i_d_douten,
    input  logic [DATA_WIDTH-1:0]  i_d_dout,
    output logic [31:0]            o_wr_cnt,
    output logic [31:0]            o_rd_cnt,
    output logic [31:0]            o_err_cnt,
    output logic                   o_err_flag,
    output logic [31:0]            o_first_err_idx,
    output logic                   o_done
);

    localparam int LANES = DATA_WIDTH / 32;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_run;
    logic                  w_wr_adv;
    logic                  w_chk_adv;
    logic [DATA_WIDTH-1:0] w_exp_beat;
    logic [LANES-1:0]      w_lane_mis;
    logic                  w_acc_valid;
    logic                  w_acc_any;
    logic [31:0]           w_acc_idx;
    logic [31:0]           r_wr_cnt;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_err_cnt;
    logic                  r_err_flag;
    logic [31:0]           r_first_err_idx;
    logic                  r_done;
    logic [31:0]           r_expect_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // START wins over any beat in the same cycle, so it also masks the advances
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        if (i_start) w_state_nxt = ST_RUN;
        else if (r_state == ST_RUN) w_run = 1'b1;
        w_wr_adv  = w_run & i_d_w;
        w_chk_adv = w_run & i_d_douten;
    end

    stream_pattern_gen #(.LANES(LANES)) u_wr_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (i_start),
        .i_mode (i_mode),
        .i_seed (i_seed),
        .i_adv  (w_wr_adv),
        .o_beat (o_d_din)
    );

    stream_pattern_gen #(.LANES(LANES)) u_chk_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (i_start),
        .i_mode (i_mode),
        .i_seed (i_seed),
        .i_adv  (w_chk_adv),
        .o_beat (w_exp_beat)
    );

    always_comb begin
        w_lane_mis = '0;
        for (int j = 0; j < LANES; j++)
            w_lane_mis[j] = (i_d_dout[j*32 +: 32] != w_exp_beat[j*32 +: 32]);
    end

    generate
        if (CMP_PIPE != 0) begin : g_pipe
            logic             r_s1_valid;
            logic [LANES-1:0] r_s1_mis;
            logic [31:0]      r_s1_idx;

            // A START cycle has w_chk_adv low, which flushes the pending compare
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1_mis   <= '0;
                    r_s1_idx   <= '0;
                end else begin
                    r_s1_valid <= w_chk_adv;
                    if (w_chk_adv) begin
                        r_s1_mis <= w_lane_mis;
                        r_s1_idx <= r_rd_cnt;
                    end
                end
            end
            assign w_acc_valid = r_s1_valid;
            assign w_acc_any   = |r_s1_mis;
            assign w_acc_idx   = r_s1_idx;
        end else begin : g_nopipe
            assign w_acc_valid = w_chk_adv;
            assign w_acc_any   = |w_lane_mis;
            assign w_acc_idx   = r_rd_cnt;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_err_cnt       <= '0;
            r_err_flag      <= 1'b0;
            r_first_err_idx <= '0;
            r_done          <= 1'b0;
            r_expect_n      <= '0;
        end else if (i_start) begin
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_err_cnt       <= '0;
            r_err_flag      <= 1'b0;
            r_first_err_idx <= '0;
            r_done          <= 1'b0;
            r_expect_n      <= i_expect_n;
        end else begin
            if (w_wr_adv)  r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_chk_adv) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_acc_valid) begin
                if (w_acc_any) begin
                    if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
                    if (!r_err_flag) begin
                        r_err_flag      <= 1'b1;
                        r_first_err_idx <= w_acc_idx;
                    end
                end
                if ((r_expect_n != 32'd0) && (w_acc_idx == r_expect_n - 32'd1))
                    r_done <= 1'b1;
            end
        end
    end

    assign o_wr_cnt        = r_wr_cnt;
    assign o_rd_cnt        = r_rd_cnt;
    assign o_err_cnt       = r_err_cnt;
    assign o_err_flag      = r_err_flag;
    assign o_first_err_idx = r_first_err_idx;
    assign o_done          = r_done;

endmodule
